// File: rtl/operand_fetch_pkg.sv
// Shared constants, FSM encoding and latched-instruction layout for operand_fetch.
package operand_fetch_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IDX_W  = 3;
  localparam int unsigned DEF_OP_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_ISSUE_B = 3'd2,
    ST_CAPT_B  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_IDX_W-1:0]  rs;
    logic [DEF_IDX_W-1:0]  rt;
    logic [DEF_IDX_W-1:0]  rd;
    logic                  use_imm;
    logic [DEF_DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side instruction handshake and ALU-side operand handshake.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned OP_W   = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [IDX_W-1:0]  in_rs;
  logic [IDX_W-1:0]  in_rt;
  logic [IDX_W-1:0]  in_rd;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [OP_W-1:0]   out_op;
  logic [IDX_W-1:0]  out_rd;

  // Environment side: supplies instructions, consumes operands.
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_use_imm, in_imm, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_rd
  );

  // Operand fetch stage side.
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_use_imm, in_imm, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_rd
  );

endinterface

// File: rtl/operand_fwd_slot.sv
// One operand's writeback-forwarding tracker and capture register.
module operand_fwd_slot #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              win,
  input  logic [IDX_W-1:0]  match_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_index,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              capture,
  input  logic [DATA_W-1:0] rf_val,
  output logic [DATA_W-1:0] operand,
  output logic              fwd
);

  logic [DATA_W-1:0] fwd_data;
  logic              hit;

  assign hit = win && wb_valid && (wb_index == match_idx);

  // Track the youngest matching writeback in the window; capture with a
  // same-edge writeback taking priority over older forwarded data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd      <= 1'b0;
      fwd_data <= '0;
      operand  <= '0;
    end else begin
      if (hit) begin
        fwd      <= 1'b1;
        fwd_data <= wb_data;
      end else if (clear) begin
        fwd      <= 1'b0;
      end
      if (capture) begin
        if (hit)      operand <= wb_data;
        else if (fwd) operand <= fwd_data;
        else          operand <= rf_val;
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Fetches rs/rt through the single register-file read port, forwards
// in-flight writebacks, and hands both operands to the ALU stage.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_if.slave    bus,
  output logic [IDX_W-1:0]  rf_index,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_index,
  input  logic [DATA_W-1:0] wb_data
);

  state_t            state;
  instr_t            lat;
  logic              out_valid;
  logic              accept;
  logic              win_a;
  logic              win_b;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              unused_fwd_a;
  logic              unused_fwd_b;

  assign accept = (state == ST_IDLE) && bus.in_valid;

  // Forward windows open on the accept edge, before the instruction is
  // latched, so the live input indices are matched on that edge.
  always_comb begin
    idx_a = accept ? bus.in_rs : lat.rs;
    idx_b = accept ? bus.in_rt : lat.rt;
    win_a = accept || (state == ST_ISSUE_A) || (state == ST_ISSUE_B);
    if (accept) win_b = !bus.in_use_imm;
    else        win_b = !lat.use_imm && ((state == ST_ISSUE_A) ||
                                         (state == ST_ISSUE_B) ||
                                         (state == ST_CAPT_B));
    // With an immediate the B window stays shut, so the slot captures imm.
    src_b = lat.use_imm ? lat.imm : rf_val;
  end

  operand_fwd_slot #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .win       (win_a),
    .match_idx (idx_a),
    .wb_valid  (wb_valid),
    .wb_index  (wb_index),
    .wb_data   (wb_data),
    .capture   (state == ST_ISSUE_B),
    .rf_val    (rf_val),
    .operand   (op_a),
    .fwd       (unused_fwd_a)
  );

  operand_fwd_slot #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .win       (win_b),
    .match_idx (idx_b),
    .wb_valid  (wb_valid),
    .wb_index  (wb_index),
    .wb_data   (wb_data),
    .capture   (state == ST_CAPT_B),
    .rf_val    (src_b),
    .operand   (op_b),
    .fwd       (unused_fwd_b)
  );

  // Sequencer: issue rs then rt to the register file, then hold for the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rf_index  <= '0;
      out_valid <= 1'b0;
      lat       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            lat.op      <= bus.in_op;
            lat.rs      <= bus.in_rs;
            lat.rt      <= bus.in_rt;
            lat.rd      <= bus.in_rd;
            lat.use_imm <= bus.in_use_imm;
            lat.imm     <= bus.in_imm;
            rf_index    <= bus.in_rs;
            state       <= ST_ISSUE_A;
          end
        end
        ST_ISSUE_A: begin
          rf_index <= lat.rt;
          state    <= ST_ISSUE_B;
        end
        ST_ISSUE_B: state <= ST_CAPT_B;
        ST_CAPT_B: begin
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_a     = op_a;
  assign bus.out_b     = op_b;
  assign bus.out_op    = lat.op;
  assign bus.out_rd    = lat.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] rf_index;
  logic [DW-1:0] rf_val;
  logic          wb_valid;
  logic [IW-1:0] wb_index;
  logic [DW-1:0] wb_data;

  logic [DW-1:0] mem [8];
  logic          wb_v [16];
  logic [IW-1:0] wb_i [16];
  logic [DW-1:0] wb_d [16];

  int tot = 0;
  int pass_cnt = 0;

  operand_fetch_if #(.DATA_W(DW), .IDX_W(IW), .OP_W(OW)) bus ();

  operand_fetch #(.DATA_W(DW), .IDX_W(IW), .OP_W(OW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .rf_index (rf_index),
    .rf_val   (rf_val),
    .wb_valid (wb_valid),
    .wb_index (wb_index),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  // Register file: read data reflects the index sampled at the previous edge.
  always @(posedge clk) rf_val <= mem[rf_index];

  task automatic clear_wb();
    for (int k = 0; k < 16; k++) begin
      wb_v[k] = 1'b0; wb_i[k] = '0; wb_d[k] = '0;
    end
  endtask

  task automatic drive_wb(input int k);
    wb_valid = wb_v[k]; wb_index = wb_i[k]; wb_data = wb_d[k];
  endtask

  // k = 0 is the accept edge, k = 2 the A capture edge, k = 3 the B capture edge.
  task automatic run_instr(input logic [OW-1:0] op, input logic [IW-1:0] rs,
                           input logic [IW-1:0] rt, input logic [IW-1:0] rd,
                           input logic use_imm, input logic [DW-1:0] imm,
                           input int hold, input bit keep_valid, input string name);
    logic [DW-1:0] ea, eb;
    ea = mem[rs];
    for (int k = 0; k <= 2; k++) if (wb_v[k] && wb_i[k] == rs) ea = wb_d[k];
    if (use_imm) eb = imm;
    else begin
      eb = mem[rt];
      for (int k = 0; k <= 3; k++) if (wb_v[k] && wb_i[k] == rt) eb = wb_d[k];
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_rd = rd; bus.in_use_imm = use_imm; bus.in_imm = imm; drive_wb(0);
    tot++; if (bus.in_ready !== 1'b1) $display("FAIL %s idle_ready got %b want 1", name, bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    if (!keep_valid) bus.in_valid = 1'b0;
    drive_wb(1);
    tot++; if (rf_index !== rs) $display("FAIL %s rf_index_rs got %0d want %0d", name, rf_index, rs); else pass_cnt++;
    tot++; if (bus.in_ready !== 1'b0) $display("FAIL %s busy_ready got %b want 0", name, bus.in_ready); else pass_cnt++;
    @(posedge clk); #1;
    drive_wb(2);
    tot++; if (rf_index !== rt) $display("FAIL %s rf_index_rt got %0d want %0d", name, rf_index, rt); else pass_cnt++;
    @(posedge clk); #1;
    drive_wb(3);
    tot++; if (bus.out_valid !== 1'b0) $display("FAIL %s early_valid got %b want 0", name, bus.out_valid); else pass_cnt++;
    @(posedge clk); #1;
    drive_wb(4);
    tot++; if (bus.out_valid !== 1'b1) $display("FAIL %s latency_valid got %b want 1", name, bus.out_valid); else pass_cnt++;
    tot++; if (bus.out_a !== ea) $display("FAIL %s out_a got %h want %h", name, bus.out_a, ea); else pass_cnt++;
    tot++; if (bus.out_b !== eb) $display("FAIL %s out_b got %h want %h", name, bus.out_b, eb); else pass_cnt++;
    tot++; if (bus.out_op !== op) $display("FAIL %s out_op got %h want %h", name, bus.out_op, op); else pass_cnt++;
    tot++; if (bus.out_rd !== rd) $display("FAIL %s out_rd got %h want %h", name, bus.out_rd, rd); else pass_cnt++;
    for (int j = 0; j < hold; j++) begin
      @(posedge clk); #1;
      drive_wb(5 + j);
      tot++;
      if (bus.out_valid !== 1'b1 || bus.out_a !== ea || bus.out_b !== eb || bus.in_ready !== 1'b0)
        $display("FAIL %s hold got v=%b a=%h b=%h rdy=%b want v=1 a=%h b=%h rdy=0",
                 name, bus.out_valid, bus.out_a, bus.out_b, bus.in_ready, ea, eb);
      else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; wb_valid = 1'b0;
    tot++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL %s handshake got v=%b rdy=%b want v=0 rdy=1", name, bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_use_imm = 1'b0; bus.in_imm = '0;
    wb_valid = 1'b0; wb_index = '0; wb_data = '0;
    for (int r = 0; r < 8; r++) mem[r] = 8'(r * 17 + 1);
    clear_wb();
    @(negedge clk); @(negedge clk);
    tot++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || rf_index !== '0 ||
               bus.out_a !== '0 || bus.out_b !== '0 || bus.out_op !== '0 || bus.out_rd !== '0)
      $display("FAIL reset_values got rdy=%b v=%b idx=%0d a=%h b=%h op=%h rd=%h want 1 0 0 00 00 0 0",
               bus.in_ready, bus.out_valid, rf_index, bus.out_a, bus.out_b, bus.out_op, bus.out_rd);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tot++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || rf_index !== '0)
        $display("FAIL reset_idle cycle %0d got rdy=%b v=%b idx=%0d want 1 0 0", c, bus.in_ready, bus.out_valid, rf_index);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    mem[3] = 8'h5A; mem[6] = 8'hC3; clear_wb();
    run_instr(4'd2, 3'd3, 3'd6, 3'd1, 1'b0, 8'h00, 0, 1'b0, "basic");
  endtask

  task automatic test_imm();
    mem[2] = 8'h10; clear_wb();
    wb_v[1] = 1'b1; wb_i[1] = 3'd4; wb_d[1] = 8'hAB;  // write to rt must be ignored
    run_instr(4'd5, 3'd2, 3'd4, 3'd7, 1'b1, 8'h7F, 1, 1'b0, "imm");
  endtask

  task automatic test_forward();
    mem[3] = 8'h5A; clear_wb();
    wb_v[1] = 1'b1; wb_i[1] = 3'd3; wb_d[1] = 8'hEE;
    for (int k = 4; k < 8; k++) begin wb_v[k] = 1'b1; wb_i[k] = 3'd3; wb_d[k] = 8'h11; end
    run_instr(4'd1, 3'd3, 3'd3, 3'd0, 1'b0, 8'h00, 3, 1'b0, "fwd_issue_a");
    mem[5] = 8'h50; mem[6] = 8'h60; clear_wb();
    wb_v[0] = 1'b1; wb_i[0] = 3'd5; wb_d[0] = 8'h21;
    wb_v[2] = 1'b1; wb_i[2] = 3'd5; wb_d[2] = 8'h22;
    wb_v[3] = 1'b1; wb_i[3] = 3'd6; wb_d[3] = 8'h66;
    run_instr(4'd3, 3'd5, 3'd6, 3'd2, 1'b0, 8'h00, 1, 1'b0, "fwd_capture_edges");
    clear_wb();
    wb_v[0] = 1'b1; wb_i[0] = 3'd6; wb_d[0] = 8'h77;
    wb_v[3] = 1'b1; wb_i[3] = 3'd5; wb_d[3] = 8'h99;
    run_instr(4'd4, 3'd5, 3'd6, 3'd3, 1'b0, 8'h00, 0, 1'b0, "fwd_late_a");
  endtask

  task automatic test_back_to_back();
    mem[1] = 8'h31; mem[4] = 8'h34; clear_wb();
    run_instr(4'd9, 3'd1, 3'd4, 3'd5, 1'b0, 8'h00, 5, 1'b1, "backpressure");
    run_instr(4'd6, 3'd4, 3'd1, 3'd6, 1'b0, 8'h00, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_midop_reset();
    mem[1] = 8'hA1; mem[2] = 8'hB2; clear_wb();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'd7; bus.in_rs = 3'd5; bus.in_rt = 3'd6;
    bus.in_rd = 3'd4; bus.in_use_imm = 1'b0;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #1;            // now in ISSUE_B
    rst_n = 1'b0; #1;
    tot++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || rf_index !== '0)
      $display("FAIL midop_reset got v=%b rdy=%b idx=%0d want 0 1 0", bus.out_valid, bus.in_ready, rf_index);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    run_instr(4'd8, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 0, 1'b0, "after_midop_reset");
    // Reset while operands are presented.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 4'd9; bus.in_rs = 3'd1; bus.in_rt = 3'd2; bus.in_rd = 3'd7;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tot++; if (bus.out_valid !== 1'b1) $display("FAIL hold_before_reset got v=%b want 1", bus.out_valid); else pass_cnt++;
    rst_n = 1'b0; #1;
    tot++; if (bus.out_valid !== 1'b0 || bus.out_a !== '0 || bus.out_b !== '0 || bus.out_op !== '0 ||
               bus.out_rd !== '0 || bus.in_ready !== 1'b1)
      $display("FAIL hold_reset got v=%b a=%h b=%h op=%h rd=%h rdy=%b want 0 00 00 0 0 1",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_op, bus.out_rd, bus.in_ready);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [IW-1:0] rs, rt;
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 8; r++) mem[r] = 8'($urandom);
      rs = 3'($urandom); rt = ($urandom_range(0, 3) == 0) ? rs : 3'($urandom);
      for (int k = 0; k < 16; k++) begin
        wb_v[k] = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 2))
          0: wb_i[k] = rs;
          1: wb_i[k] = rt;
          default: wb_i[k] = 3'($urandom);
        endcase
        wb_d[k] = 8'($urandom);
      end
      run_instr(4'($urandom), rs, rt, 3'($urandom), 1'($urandom_range(0, 3) == 0),
                8'($urandom), $urandom_range(0, 3), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_forward();
    test_back_to_back();
    test_midop_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule
